adxl345_sequencer: RTL and testbench
====================================

# adxl345_sequencer

Autonomous controller that drives the ADXL345 SPI engine, the block that shifts command/data bits and latches X/Y/Z. After reset it issues three single-byte configuration writes (BW_RATE, DATA_FORMAT, POWER_CTL). It then issues a 6-byte multi-byte burst read from DATAX0 every SAMPLE_PERIOD clocks. It sits between the top level and the SPI engine, owning every engine command input, and flags a stuck engine with a watchdog.

## Interface
Parameters:
- SAMPLE_PERIOD, 500000: clocks between read starts (100 Hz at 50 MHz); must be at least 2.
- GAP_CYCLES, 16: idle clocks between consecutive transactions (CS high time).
- TIMEOUT_CYCLES, 4096: watchdog limit per transaction phase.
- BW_RATE_VAL, 8'h0A; DATA_FORMAT_VAL, 8'h0B; POWER_CTL_VAL, 8'h08: configuration bytes.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  run request
- busy_i  in  1  engine busy (from SPI engine)
- complete_i  in  1  engine one-cycle completion pulse
- req_o  out  1  transaction request to engine
- re_o  out  1  1 = read, 0 = write
- mb_o  out  1  multi-byte bit
- addr_o  out  6  register address
- data_o  out  8  write data
- remain_byte_o  out  3  data bytes minus one
- init_done_o  out  1  configuration finished
- sample_valid_o  out  1  one-cycle pulse; engine X/Y/Z outputs are fresh
- overrun_o  out  1  sticky; a read exceeded SAMPLE_PERIOD
- err_o  out  1  watchdog expired

## Operation
- States: IDLE, CFG_REQ, CFG_WAIT, GAP, READ_REQ, READ_WAIT, PERIOD_WAIT, ERROR. A 2-bit cfg_idx selects the config write: 0 = BW_RATE 0x2C, 1 = DATA_FORMAT 0x31, 2 = POWER_CTL 0x2D.
- IDLE: all outputs 0 except as listed under reset. enable_i=1 moves to CFG_REQ with cfg_idx=0, or to READ_REQ if init_done_o is already 1.
- CFG_REQ: re_o=0, mb_o=0, remain_byte_o=0, addr_o/data_o from cfg_idx, req_o=1. Moves to CFG_WAIT when busy_i=1.
- CFG_WAIT: when complete_i=1, cfg_idx increments and the FSM moves to GAP. After idx 2, init_done_o is set (stays 1 until reset).
- GAP: waits GAP_CYCLES, then goes to CFG_REQ if config writes remain, otherwise to PERIOD_WAIT with the period timer at 0.
- READ_REQ: re_o=1, mb_o=1, addr_o=6'h32, data_o=0, remain_byte_o=3'd5, req_o=1. Entry reloads the period timer to SAMPLE_PERIOD-1. Moves to READ_WAIT on busy_i=1.
- READ_WAIT: complete_i=1 pulses sample_valid_o next cycle and moves to PERIOD_WAIT.
- PERIOD_WAIT: enable_i=0 moves to IDLE. Otherwise, when the timer reaches 0, moves to READ_REQ.
- The period timer decrements every cycle in all states and saturates at 0. If the timer is already 0 on entering PERIOD_WAIT after a read, overrun_o is set.
- Watchdog: reloads on entry to any REQ or WAIT state. Expiry (TIMEOUT_CYCLES clocks without advancing) moves to ERROR.
- ERROR: req_o=0, err_o=1. enable_i=0 returns to IDLE and clears err_o. init_done_o is cleared so configuration reruns.
- enable_i is ignored in REQ, WAIT and GAP states; an in-flight transaction always completes.
- Command outputs hold stable from REQ entry until complete_i.

## Timing
- Reset: state IDLE, every output 0, counters 0, cfg_idx 0.
- req_o rises the cycle after the REQ state is entered (registered outputs). It falls the cycle after busy_i=1 is sampled.
- complete_i arriving together with busy_i is treated as acceptance plus completion.
- sample_valid_o is high exactly 1 cycle, 1 clock after the complete_i sample.
- Read start spacing is exactly SAMPLE_PERIOD clocks when the read plus gap fits within the period.
- Reset asserted mid-transaction takes effect immediately and asynchronously; req_o drops to 0.

## Structure
- adxl345_pkg holds the register address constants (0x2C, 0x31, 0x2D, 0x32), the seq_state_t enum, and READ_BYTES_M1 = 3'd5.
- One sub-module, adxl345_down_counter: loadable, saturating-at-zero, parameterised width, zero flag. Three instances: period, gap, watchdog.

## Test plan
- Reset, then enable_i=1 with an engine model (busy 20 clk, then complete): writes 0x2C/0x0A, 0x31/0x0B, 0x2D/0x08 in order, each spaced at least 16 clk idle; init_done_o=1 after the third.
- Steady state with SAMPLE_PERIOD=1000: read starts at exact 1000-clk spacing with addr 0x32, mb=1, remain_byte=5; one sample_valid_o pulse per read.
- Engine holds busy_i=0: err_o=1 exactly 4096 clk after req_o rises. enable_i=0 returns to IDLE and clears err_o; re-enable reruns configuration.
- Engine completion takes 1200 clk with SAMPLE_PERIOD=1000: overrun_o set; next read begins GAP_CYCLES after completion.
- enable_i dropped during READ_WAIT: read completes, sample_valid_o pulses, FSM then returns to IDLE. Re-enable skips configuration.
- rst_ni pulsed low mid-CFG_WAIT: all outputs 0 immediately; after release the sequence restarts at cfg_idx 0.

Source files
------------

// File: rtl/adxl345_pkg.sv
// rtl/adxl345_pkg.sv - ADXL345 register map, sequencer states and shared helpers
package adxl345_pkg;

  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [2:0] READ_BYTES_M1    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_REQ,
    ST_CFG_WAIT,
    ST_GAP,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_PERIOD_WAIT,
    ST_ERROR
  } seq_state_t;

  function automatic logic [5:0] cfg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return ADDR_BW_RATE;
      2'd1:    return ADDR_DATA_FORMAT;
      default: return ADDR_POWER_CTL;
    endcase
  endfunction

endpackage

// File: rtl/adxl345_down_counter.sv
// rtl/adxl345_down_counter.sv - loadable down counter that saturates at zero
module adxl345_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero_o = (r_count == '0);

endmodule

// File: rtl/adxl345_sequencer.sv
// rtl/adxl345_sequencer.sv - configures the ADXL345 then issues periodic 6-byte XYZ burst reads
module adxl345_sequencer
  import adxl345_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD   = 500000,
  parameter int unsigned GAP_CYCLES      = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
  parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
  parameter logic [7:0]  POWER_CTL_VAL   = 8'h08
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       busy_i,
  input  logic       complete_i,
  output logic       req_o,
  output logic       re_o,
  output logic       mb_o,
  output logic [5:0] addr_o,
  output logic [7:0] data_o,
  output logic [2:0] remain_byte_o,
  output logic       init_done_o,
  output logic       sample_valid_o,
  output logic       overrun_o,
  output logic       err_o
);

  localparam int PERIOD_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PERIOD_W-1:0] PERIOD_RELOAD = PERIOD_W'(SAMPLE_PERIOD - 1);
  localparam logic [GAP_W-1:0]    GAP_RELOAD    = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]     WD_RELOAD     = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_t r_state, w_next;
  logic [1:0] r_cfg_idx;
  logic       r_init_done, r_overrun, r_sample_valid, r_err, r_req, r_re, r_mb;
  logic [5:0] r_addr;
  logic [7:0] r_data;
  logic [2:0] r_remain;

  logic                w_done, w_is_cfg, w_is_read;
  logic                w_period_zero, w_gap_zero, w_wd_zero;
  logic                w_period_to_read, w_period_load, w_wd_load;
  logic [PERIOD_W-1:0] w_period_val;
  logic [7:0]          w_cfg_data;

  assign w_is_cfg  = (r_state == ST_CFG_REQ)  || (r_state == ST_CFG_WAIT);
  assign w_is_read = (r_state == ST_READ_REQ) || (r_state == ST_READ_WAIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // complete_i seen in a REQ state counts as acceptance and completion together
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) w_next = r_init_done ? ST_READ_REQ : ST_CFG_REQ;
      end
      ST_CFG_REQ, ST_READ_REQ: begin
        if (busy_i && complete_i) begin
          w_done = 1'b1;
          w_next = (r_state == ST_CFG_REQ) ? ST_GAP : ST_PERIOD_WAIT;
        end else if (busy_i) begin
          w_next = (r_state == ST_CFG_REQ) ? ST_CFG_WAIT : ST_READ_WAIT;
        end else if (w_wd_zero) begin
          w_next = ST_ERROR;
        end
      end
      ST_CFG_WAIT, ST_READ_WAIT: begin
        if (complete_i) begin
          w_done = 1'b1;
          w_next = (r_state == ST_CFG_WAIT) ? ST_GAP : ST_PERIOD_WAIT;
        end else if (w_wd_zero) begin
          w_next = ST_ERROR;
        end
      end
      ST_GAP: begin
        if (w_gap_zero) w_next = (r_cfg_idx == 2'd3) ? ST_PERIOD_WAIT : ST_CFG_REQ;
      end
      ST_PERIOD_WAIT: begin
        if (!enable_i) begin
          w_next = ST_IDLE;
        end else if (w_period_zero && w_gap_zero) begin
          w_next = ST_READ_REQ;
        end
      end
      ST_ERROR: begin
        if (!enable_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_period_to_read = (w_next == ST_READ_REQ) && (r_state != ST_READ_REQ);
  assign w_period_load    = w_period_to_read || ((r_state == ST_GAP) && (w_next == ST_PERIOD_WAIT));
  assign w_period_val     = w_period_to_read ? PERIOD_RELOAD : '0;
  assign w_wd_load        = (w_next != r_state) &&
                            (w_next inside {ST_CFG_REQ, ST_CFG_WAIT, ST_READ_REQ, ST_READ_WAIT});

  // Gap timer restarts on every completion so reads also keep the CS-high gap
  adxl345_down_counter #(.WIDTH(PERIOD_W)) u_period (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_period_load),
    .load_val_i (w_period_val),
    .zero_o     (w_period_zero)
  );

  adxl345_down_counter #(.WIDTH(GAP_W)) u_gap (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_done),
    .load_val_i (GAP_RELOAD),
    .zero_o     (w_gap_zero)
  );

  adxl345_down_counter #(.WIDTH(WD_W)) u_watchdog (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_wd_load),
    .load_val_i (WD_RELOAD),
    .zero_o     (w_wd_zero)
  );

  always_comb begin
    w_cfg_data = POWER_CTL_VAL;
    case (r_cfg_idx)
      2'd0:    w_cfg_data = BW_RATE_VAL;
      2'd1:    w_cfg_data = DATA_FORMAT_VAL;
      default: w_cfg_data = POWER_CTL_VAL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg_idx   <= 2'd0;
      r_init_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && (w_next == ST_CFG_REQ)) begin
        r_cfg_idx <= 2'd0;
      end else if (w_done && w_is_cfg) begin
        r_cfg_idx <= r_cfg_idx + 2'd1;
      end
      if (w_next == ST_ERROR) begin
        r_init_done <= 1'b0;
      end else if (w_done && w_is_cfg && (r_cfg_idx == 2'd2)) begin
        r_init_done <= 1'b1;
      end
      if (w_done && w_is_read && w_period_zero) r_overrun <= 1'b1;
    end
  end

  // Command fields are captured while in REQ and then held until the next REQ
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req          <= 1'b0;
      r_err          <= 1'b0;
      r_sample_valid <= 1'b0;
      r_re           <= 1'b0;
      r_mb           <= 1'b0;
      r_addr         <= 6'h00;
      r_data         <= 8'h00;
      r_remain       <= 3'd0;
    end else begin
      r_req          <= (r_state == ST_CFG_REQ) || (r_state == ST_READ_REQ);
      r_err          <= (r_state == ST_ERROR);
      r_sample_valid <= w_done && w_is_read;
      case (r_state)
        ST_CFG_REQ: begin
          r_re     <= 1'b0;
          r_mb     <= 1'b0;
          r_addr   <= cfg_addr(r_cfg_idx);
          r_data   <= w_cfg_data;
          r_remain <= 3'd0;
        end
        ST_READ_REQ: begin
          r_re     <= 1'b1;
          r_mb     <= 1'b1;
          r_addr   <= ADDR_DATAX0;
          r_data   <= 8'h00;
          r_remain <= READ_BYTES_M1;
        end
        ST_IDLE, ST_ERROR: begin
          r_re     <= 1'b0;
          r_mb     <= 1'b0;
          r_addr   <= 6'h00;
          r_data   <= 8'h00;
          r_remain <= 3'd0;
        end
        default: ;
      endcase
    end
  end

  assign req_o          = r_req;
  assign re_o           = r_re;
  assign mb_o           = r_mb;
  assign addr_o         = r_addr;
  assign data_o         = r_data;
  assign remain_byte_o  = r_remain;
  assign init_done_o    = r_init_done;
  assign sample_valid_o = r_sample_valid;
  assign overrun_o      = r_overrun;
  assign err_o          = r_err;

endmodule

// File: tb/tb_adxl345_sequencer.sv
// tb/tb_adxl345_sequencer.sv - directed bench for adxl345_sequencer with a behavioural SPI engine
module tb_adxl345_sequencer;

  localparam int SP  = 1000;
  localparam int GAP = 16;
  localparam int TO  = 4096;

  logic       clk_i = 1'b0;
  logic       rst_ni, enable_i, busy_i, complete_i;
  logic       req_o, re_o, mb_o, init_done_o, sample_valid_o, overrun_o, err_o;
  logic [5:0] addr_o;
  logic [7:0] data_o;
  logic [2:0] remain_byte_o;

  adxl345_sequencer #(
    .SAMPLE_PERIOD(SP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO),
    .BW_RATE_VAL(8'h0A), .DATA_FORMAT_VAL(8'h0B), .POWER_CTL_VAL(8'h08)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .busy_i(busy_i),
    .complete_i(complete_i), .req_o(req_o), .re_o(re_o), .mb_o(mb_o),
    .addr_o(addr_o), .data_o(data_o), .remain_byte_o(remain_byte_o),
    .init_done_o(init_done_o), .sample_valid_o(sample_valid_o),
    .overrun_o(overrun_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int busy_len = 20;
  bit engine_on = 1'b1;
  int busy_cnt = 0;
  logic prev_req = 1'b0, prev_err = 1'b0;
  int last_rise = 0, err_rise = 0, sv_cnt = 0, sv_last = 0, sv_run = 0, sv_max = 0;
  int q_rise[$], q_addr[$], q_data[$], q_flags[$], q_comp[$];
  int exp_addr[3] = '{'h2C, 'h31, 'h2D};
  int exp_data[3] = '{'h0A, 'h0B, 'h08};
  int pre_addr;
  int k;

  // Engine model: accepts req_o, holds busy for busy_len clocks, then pulses complete
  initial begin
    busy_i = 1'b0;
    complete_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      complete_i = 1'b0;
      if (req_o && !prev_req) last_rise = cyc;
      prev_req = req_o;
      if (err_o && !prev_err) err_rise = cyc;
      prev_err = err_o;
      if (sample_valid_o) begin
        sv_cnt++;
        sv_last = cyc;
        sv_run++;
        if (sv_run > sv_max) sv_max = sv_run;
      end else begin
        sv_run = 0;
      end
      if (!rst_ni) begin
        busy_i = 1'b0;
        busy_cnt = 0;
      end else if (busy_cnt != 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          busy_i = 1'b0;
          complete_i = 1'b1;
          q_comp.push_back(cyc);
        end
      end else if (req_o && engine_on && !busy_i) begin
        busy_i = 1'b1;
        busy_cnt = busy_len;
        q_rise.push_back(cyc);
        q_addr.push_back(int'(addr_o));
        q_data.push_back(int'(data_o));
        q_flags.push_back(int'({re_o, mb_o, remain_byte_o}));
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int i = 0;
    while (q_rise.size() < n && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    chk(tag, longint'(q_rise.size() >= n), 1);
  endtask

  task automatic wait_comp(input int n, input int budget, input string tag);
    int i = 0;
    while (q_comp.size() < n && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    chk(tag, longint'(q_comp.size() >= n), 1);
  endtask

  initial begin
    rst_ni = 1'b0;
    enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_req", req_o, 0);
    chk("rst_cmd", {re_o, mb_o, addr_o, data_o, remain_byte_o}, 0);
    chk("rst_status", {init_done_o, sample_valid_o, overrun_o, err_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    enable_i = 1'b1;

    wait_log(3, 400, "cfg_start");
    chk("cfg_init_before_last", init_done_o, 0);
    wait_comp(3, 400, "cfg_done");
    repeat (2) @(negedge clk_i);
    chk("cfg_init_done", init_done_o, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cfg_addr%0d", i), q_addr[i], exp_addr[i]);
      chk($sformatf("cfg_data%0d", i), q_data[i], exp_data[i]);
      chk($sformatf("cfg_flags%0d", i), q_flags[i], 0);
    end
    for (int i = 0; i < 2; i++)
      chk($sformatf("cfg_gap%0d", i), longint'((q_rise[i+1] - q_comp[i]) >= GAP + 1), 1);

    wait_comp(6, 3500, "reads_done");
    repeat (2) @(negedge clk_i);
    chk("read_spacing0", q_rise[4] - q_rise[3], SP);
    chk("read_spacing1", q_rise[5] - q_rise[4], SP);
    for (int i = 3; i < 6; i++) begin
      chk($sformatf("read_addr%0d", i), q_addr[i], 'h32);
      chk($sformatf("read_flags%0d", i), q_flags[i], 'b11101);
    end
    chk("sv_count", sv_cnt, 3);
    chk("sv_width", sv_max, 1);
    chk("sv_latency", sv_last, q_comp[5] + 1);
    chk("no_overrun", overrun_o, 0);

    busy_len = 1200;
    wait_log(7, 1100, "ovr_start");
    busy_len = 20;
    wait_comp(7, 1400, "ovr_done");
    wait_log(8, 100, "ovr_next");
    chk("overrun_set", overrun_o, 1);
    chk("ovr_next_start", q_rise[7] - q_comp[6], GAP + 2);

    wait_log(9, 1100, "drop_start");
    repeat (5) @(negedge clk_i);
    enable_i = 1'b0;
    wait_comp(9, 100, "drop_done");
    repeat (3) @(negedge clk_i);
    chk("drop_sv", sv_cnt, 6);
    repeat (1500) @(negedge clk_i);
    chk("drop_idle", q_rise.size(), 9);
    chk("drop_req_low", req_o, 0);
    enable_i = 1'b1;
    wait_log(10, 10, "reen_start");
    chk("reen_addr", q_addr[9], 'h32);
    chk("reen_flags", q_flags[9], 'b11101);
    chk("reen_init", init_done_o, 1);

    wait_comp(10, 100, "reen_done");
    engine_on = 1'b0;
    k = 0;
    while (!err_o && k < 6000) begin
      @(negedge clk_i);
      k++;
    end
    chk("wd_err", err_o, 1);
    chk("wd_time", err_rise - last_rise, TO);
    chk("wd_req_low", req_o, 0);
    chk("wd_init_clr", init_done_o, 0);
    enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("err_clear", err_o, 0);
    engine_on = 1'b1;
    enable_i = 1'b1;
    wait_log(11, 20, "rerun_start");
    chk("rerun_addr", q_addr[10], 'h2C);

    repeat (8) @(negedge clk_i);
    pre_addr = int'(addr_o);
    chk("arst_pre_addr", pre_addr, 'h2C);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_outs", {req_o, re_o, mb_o, addr_o, data_o, remain_byte_o,
                      init_done_o, sample_valid_o, overrun_o, err_o}, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    wait_log(12, 60, "arst_restart");
    chk("arst_addr", q_addr[11], 'h2C);
    chk("arst_data", q_data[11], 'h0A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
